if_stage: RTL



---
 rtl/if_stage_pkg.sv | 11 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/if_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: reset vector default and the 32-bit encoding marker.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  INST_LEN_32      = 2'b11;

    function automatic logic is_inst32(input logic [1:0] low_bits);
        return low_bits == INST_LEN_32;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries allocated at request, filled at response, popped by decode.
// Pointers carry one extra wrap bit, so alloc >= fill >= pop ordering encodes the filled state.
module fetch_queue #(
    parameter int  DEPTH = 2,
    parameter int  AW    = 32,
    parameter int  IW    = 32,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alloc,
    input  logic [AW-1:0] alloc_pc,
    input  logic          fill,
    input  logic [IW-1:0] fill_inst,
    input  logic          pop,
    output logic [PW:0]   count,
    output logic [PW:0]   unfilled,
    output logic          head_filled,
    output logic [AW-1:0] head_pc,
    output logic [IW-1:0] head_inst
);

    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PW:0]   fill_ptr_q, fill_ptr_d;
    logic [PW:0]   pop_ptr_q, pop_ptr_d;
    logic [AW-1:0] pc_q [DEPTH];
    logic [AW-1:0] pc_d [DEPTH];
    logic [IW-1:0] inst_q [DEPTH];
    logic [IW-1:0] inst_d [DEPTH];

    assign count       = alloc_ptr_q - pop_ptr_q;
    assign unfilled    = alloc_ptr_q - fill_ptr_q;
    assign head_filled = fill_ptr_q != pop_ptr_q;
    assign head_pc     = pc_q[pop_ptr_q[PW-1:0]];
    assign head_inst   = inst_q[pop_ptr_q[PW-1:0]];

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        pop_ptr_d   = pop_ptr_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            pop_ptr_d   = '0;
        end else begin
            if (alloc) begin
                pc_d[alloc_ptr_q[PW-1:0]] = alloc_pc;
                alloc_ptr_d               = alloc_ptr_q + PTR_ONE;
            end
            if (fill) begin
                inst_d[fill_ptr_q[PW-1:0]] = fill_inst;
                fill_ptr_d                 = fill_ptr_q + PTR_ONE;
            end
            if (pop) begin
                pop_ptr_d = pop_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
        if (rst) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            pop_ptr_q   <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            pop_ptr_q   <= pop_ptr_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches, buffers them for decode,
// and discards responses belonging to requests flushed by a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int            IW       = 32,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
    parameter int            DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_inst,
    output logic [AW-1:0] id_pc,
    output logic          id_inst_err
);

    localparam int            PW        = $clog2(DEPTH);
    localparam int            DW        = 2 * DEPTH;
    localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(DEPTH);
    localparam logic [AW-1:0] PC_STEP   = AW'(4);
    localparam logic [DW-1:0] DROP_ONE  = 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;
    logic [DW-1:0] stale;
    logic          boot_q, boot_d;
    logic          live, req_fire, rsp_drop, rsp_fill, pop;
    logic [PW:0]   q_count, q_unfilled;
    logic          q_head_filled;
    logic [AW-1:0] head_pc;
    logic [IW-1:0] head_inst;
    logic          unused_redirect_lsbs;

    // Outputs stay quiet for one cycle after reset so memory and stage leave reset together.
    assign live           = !rst && !boot_q;
    assign imem_req_valid = live && (q_count < DEPTH_CNT) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0) && (q_unfilled != '0) && !redirect_valid;

    assign id_valid    = live && q_head_filled && !redirect_valid;
    assign pop         = id_valid && id_ready;
    assign id_inst     = id_valid ? head_inst : '0;
    assign id_pc       = id_valid ? head_pc : '0;
    assign id_inst_err = id_valid && !is_inst32(head_inst[1:0]);

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .alloc       (req_fire),
        .alloc_pc    (pc_q),
        .fill        (rsp_fill),
        .fill_inst   (imem_rsp_data),
        .pop         (pop),
        .count       (q_count),
        .unfilled    (q_unfilled),
        .head_filled (q_head_filled),
        .head_pc     (head_pc),
        .head_inst   (head_inst)
    );

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        boot_d     = 1'b0;
        stale      = drop_cnt_q + DW'(q_unfilled);
        if (redirect_valid) begin
            pc_d = {redirect_pc[AW-1:2], 2'b00};
            // A response in the flush cycle retires one outstanding request, stale or live.
            drop_cnt_d = (imem_rsp_valid && (stale != '0)) ? stale - DROP_ONE : stale;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - DROP_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
            boot_q     <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
            boot_q     <= boot_d;
        end
    end

endmodule
